// File: rtl/dreg_rr_arbiter.sv
// rtl/dreg_rr_arbiter.sv - round-robin arbiter loading one shared single-entry output register
// Optional packet lock keeps a requester's grant until it sends its end-of-packet beat.
module dreg_rr_arbiter #(
    parameter  int NUM  = 4,
    parameter  int DIN  = 16,
    parameter  int LOCK = 1,
    localparam int CW   = $clog2(NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM-1:0]     din_valid,
    output logic [NUM-1:0]     din_ready,
    input  logic [NUM*DIN-1:0] din_data,
    input  logic [NUM-1:0]     din_eot,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [DIN-1:0]     dout_data,
    output logic               dout_eot,
    output logic [CW-1:0]      dout_ctrl
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   lock_idx_q, lock_idx_d;
    logic            dout_valid_q, dout_valid_d;
    logic [DIN-1:0]  dout_data_q, dout_data_d;
    logic            dout_eot_q, dout_eot_d;
    logic [CW-1:0]   dout_ctrl_q, dout_ctrl_d;

    logic            reg_ready;
    logic [NUM-1:0]  eligible;
    logic [NUM-1:0]  grant;
    logic            found;
    logic [CW-1:0]   gnt_idx;
    logic [CW:0]     scan;
    logic            xfer;
    logic            gnt_eot;
    logic [DIN-1:0]  gnt_data;

    assign reg_ready = !dout_valid_q || dout_ready;

    // While locked only the owner may be granted, even if it is idle this cycle.
    assign eligible = (state_q == S_LOCKED) ? (din_valid & (NUM'(1) << lock_idx_q)) : din_valid;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM; k++) begin
            scan = {1'b0, ptr_q} + (CW+1)'(k);
            if (scan >= (CW+1)'(NUM)) begin
                scan = scan - (CW+1)'(NUM);
            end
            if (!found && eligible[scan[CW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[CW-1:0];
            end
        end
    end

    assign grant     = found ? (NUM'(1) << gnt_idx) : '0;
    assign din_ready = (rst && reg_ready) ? grant : '0;
    assign xfer      = rst && reg_ready && found;
    assign gnt_eot   = din_eot[gnt_idx];
    assign gnt_data  = din_data[int'(gnt_idx)*DIN +: DIN];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lock_idx_d   = lock_idx_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_eot_d   = dout_eot_q;
        dout_ctrl_d  = dout_ctrl_q;

        if (reg_ready) begin
            dout_valid_d = found;
        end

        if (xfer) begin
            dout_data_d = gnt_data;
            dout_eot_d  = gnt_eot;
            dout_ctrl_d = gnt_idx;
            ptr_d       = (gnt_idx == CW'(NUM-1)) ? '0 : gnt_idx + CW'(1);
            case (state_q)
                S_IDLE: begin
                    if ((LOCK != 0) && !gnt_eot) begin
                        state_d    = S_LOCKED;
                        lock_idx_d = gnt_idx;
                    end
                end
                S_LOCKED: begin
                    if (gnt_eot) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            lock_idx_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_eot_q   <= 1'b0;
            dout_ctrl_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lock_idx_q   <= lock_idx_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_eot_q   <= dout_eot_d;
            dout_ctrl_q  <= dout_ctrl_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign dout_eot   = dout_eot_q;
    assign dout_ctrl  = dout_ctrl_q;

endmodule

// File: tb/tb_dreg_rr_arbiter.sv
// tb/tb_dreg_rr_arbiter.sv - directed scoreboard bench for dreg_rr_arbiter
module tb_dreg_rr_arbiter;

    localparam int NUM = 4;
    localparam int DIN = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM-1:0]     din_valid;
    logic [NUM-1:0]     din_ready;
    logic [NUM*DIN-1:0] din_data;
    logic [NUM-1:0]     din_eot;
    logic               dout_valid;
    logic               dout_ready;
    logic [DIN-1:0]     dout_data;
    logic               dout_eot;
    logic [1:0]         dout_ctrl;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    logic [18:0] sb_q[$];

    dreg_rr_arbiter #(.NUM(NUM), .DIN(DIN), .LOCK(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .din_eot    (din_eot),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_eot   (dout_eot),
        .dout_ctrl  (dout_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int i, input logic [15:0] d, input logic e);
        din_data[i*DIN +: DIN] = d;
        din_eot[i]             = e;
    endtask

    task automatic push(input logic [1:0] ctrl, input logic e, input logic [15:0] d);
        sb_q.push_back({ctrl, e, d});
    endtask

    // Retire the beat leaving at the coming edge, then advance one cycle.
    task automatic cyc();
        logic [18:0] exp;
        if (dout_valid && dout_ready) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                chk("beat_ctrl", 32'(dout_ctrl), 32'(exp[18:17]));
                chk("beat_eot",  32'(dout_eot),  32'(exp[16]));
                chk("beat_data", 32'(dout_data), 32'(exp[15:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        din_valid  = 4'hF;
        din_data   = '0;
        din_eot    = '0;
        dout_ready = 1'b0;
        #3;
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout_data",  32'(dout_data),  32'd0);
        chk("rst_dout_eot",   32'(dout_eot),   32'd0);
        chk("rst_dout_ctrl",  32'(dout_ctrl),  32'd0);
        chk("rst_din_ready",  32'(din_ready),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(dout_valid), 32'd0);
        chk("rst_hold_ready", 32'(din_ready),  32'd0);
        din_valid = '0;
        rst       = 1'b1;
        #1;

        // T1 single requester
        dout_ready = 1'b1;
        din_valid  = 4'b0010;
        set_beat(1, 16'h5A5A, 1'b1);
        #1;
        chk("t1_din_ready", 32'(din_ready), 32'b0010);
        push(2'd1, 1'b1, 16'h5A5A);
        cyc();
        chk("t1_dout_valid", 32'(dout_valid), 32'd1);
        chk("t1_dout_data",  32'(dout_data),  32'h5A5A);
        chk("t1_dout_ctrl",  32'(dout_ctrl),  32'd1);
        din_valid = '0;
        cyc();
        chk("t1_empty", 32'(dout_valid), 32'd0);

        // single beat from the top index wraps the pointer back to 0
        din_valid = 4'b1000;
        set_beat(3, 16'h3333, 1'b1);
        #1;
        chk("wrap_din_ready", 32'(din_ready), 32'b1000);
        push(2'd3, 1'b1, 16'h3333);
        cyc();
        din_valid = '0;
        cyc();

        // T2 fairness, one beat per cycle
        for (int i = 0; i < NUM; i++) set_beat(i, 16'h00A0 + 16'(i), 1'b1);
        din_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_din_ready", 32'(din_ready), 32'(1 << (k % 4)));
            push(2'(k % 4), 1'b1, 16'h00A0 + 16'(k % 4));
            cyc();
            chk("t2_dout_valid", 32'(dout_valid), 32'd1);
        end
        din_valid = '0;
        cyc();

        // T3 backpressure
        din_valid  = 4'b0110;
        set_beat(1, 16'hB001, 1'b1);
        set_beat(2, 16'hB002, 1'b1);
        dout_ready = 1'b0;
        #1;
        chk("t3_first_ready", 32'(din_ready), 32'b0010);
        push(2'd1, 1'b1, 16'hB001);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_ready", 32'(din_ready),  32'd0);
            chk("t3_stall_data",  32'(dout_data),  32'hB001);
            chk("t3_stall_ctrl",  32'(dout_ctrl),  32'd1);
            chk("t3_stall_eot",   32'(dout_eot),   32'd1);
            cyc();
        end
        dout_ready = 1'b1;
        #1;
        chk("t3_resume_ready", 32'(din_ready), 32'b0100);
        push(2'd2, 1'b1, 16'hB002);
        cyc();
        din_valid = '0;
        cyc();
        cyc();

        // T4 packet lock: req0 A,B,C while req2 waits
        din_valid = 4'b0101;
        set_beat(2, 16'h2222, 1'b1);
        set_beat(0, 16'h000A, 1'b0);
        #1;
        chk("t4_a_ready", 32'(din_ready), 32'b0001);
        push(2'd0, 1'b0, 16'h000A);
        cyc();
        set_beat(0, 16'h000B, 1'b0);
        #1;
        chk("t4_b_ready", 32'(din_ready), 32'b0001);
        push(2'd0, 1'b0, 16'h000B);
        cyc();
        set_beat(0, 16'h000C, 1'b1);
        #1;
        chk("t4_c_ready", 32'(din_ready), 32'b0001);
        push(2'd0, 1'b1, 16'h000C);
        cyc();
        din_valid = 4'b0100;
        #1;
        chk("t4_req2_ready", 32'(din_ready), 32'b0100);
        push(2'd2, 1'b1, 16'h2222);
        cyc();
        din_valid = '0;
        cyc();
        cyc();

        // T5 lock held across a two-cycle bubble
        din_valid = 4'b0101;
        set_beat(0, 16'h005A, 1'b0);
        #1;
        push(2'd0, 1'b0, 16'h005A);
        cyc();
        din_valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t5_bubble_ready", 32'(din_ready), 32'd0);
            cyc();
            chk("t5_bubble_valid", 32'(dout_valid), 32'd0);
        end
        din_valid = 4'b0101;
        set_beat(0, 16'h005B, 1'b0);
        #1;
        chk("t5_b_ready", 32'(din_ready), 32'b0001);
        push(2'd0, 1'b0, 16'h005B);
        cyc();
        set_beat(0, 16'h005C, 1'b1);
        #1;
        push(2'd0, 1'b1, 16'h005C);
        cyc();
        din_valid = 4'b0100;
        #1;
        chk("t5_release_ready", 32'(din_ready), 32'b0100);
        push(2'd2, 1'b1, 16'h2222);
        cyc();
        din_valid = '0;
        cyc();

        // T6 async reset while locked with a beat in flight (that beat is dropped)
        din_valid = 4'b0010;
        set_beat(1, 16'h6666, 1'b0);
        #1;
        chk("t6_lock_ready", 32'(din_ready), 32'b0010);
        cyc();
        chk("t6_inflight", 32'(dout_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_valid", 32'(dout_valid), 32'd0);
        chk("t6_async_ctrl",  32'(dout_ctrl),  32'd0);
        chk("t6_async_ready", 32'(din_ready),  32'd0);
        din_valid = 4'hF;
        for (int i = 0; i < NUM; i++) set_beat(i, 16'h0E00 + 16'(i), 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_post_ready", 32'(din_ready), 32'b0001);
        push(2'd0, 1'b1, 16'h0E00);
        cyc();
        din_valid = '0;
        cyc();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("final_idle", 32'(dout_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
